kista_cell_bist: RTL

Built-in self-test sequencer for the KISTA SOI standard-cell test chip. It drives pseudo-random stimulus into a chain of library cells under test (BUFX2, INVX1, NAND2X1, NOR2X1, DFFX1). It compacts their outputs into a multiple-input signature register (MISR) and compares the result with a golden signature. It sits directly upstream of the cell-under-test chain and consumes that chain's outputs.

---
 rtl/kista_cell_bist.sv | 138 +++++++++++++
 1 files changed

// File: rtl/kista_cell_bist.sv
// KISTA cell-chain BIST: LFSR stimulus, MISR response compaction, golden compare.
// Define KISTA_BIST_SCANOUT_EN to add SHIFT/SO serial readout of the signature in DONE.
module kista_cell_bist #(
   parameter int                LFSR_W = 16,
   parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
   parameter int                NCYC   = 256,
   parameter int                LAT    = 2,
   parameter int                NRESP  = 4,
   parameter logic [LFSR_W-1:0] GOLDEN = 16'h0000
) (
   input  logic              CK,
   input  logic              R,
   input  logic              START,
   output logic [1:0]        STIM,
   input  logic [NRESP-1:0]  RESP,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic [LFSR_W-1:0] SIG
`ifdef KISTA_BIST_SCANOUT_EN
   ,
   output logic              SO,
   input  logic              SHIFT
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [15:0] NCYC_LAST = 16'(NCYC - 1);
   localparam logic [15:0] LAT_LAST  = 16'(LAT - 1);
   localparam logic [7:0]  HIST_SEL  = 8'(1 << LAT);

   // Shared x^16+x^14+x^13+x^11+1 shift step for both LFSR and MISR
   function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   state_t            state_q;
   logic [LFSR_W-1:0] lfsr_q, misr_q;
   logic [LFSR_W-1:0] misr_d, misr_nxt_d;
   logic [15:0]       cnt_q;
   logic [1:0]        stim_q;
   logic              busy_q, done_q, pass_q;
   logic [6:0]        hist_q;
   logic [7:0]        hist_d;
   logic              upd_d;

   // hist_d[k] says "the cycle k cycles ago was a RUN cycle"; its response lands now
   always_comb begin
      hist_d     = {hist_q, state_q == S_RUN};
      upd_d      = |(hist_d & HIST_SEL);
      misr_d     = step(misr_q) ^ LFSR_W'(RESP);
      misr_nxt_d = upd_d ? misr_d : misr_q;
   end

`ifdef KISTA_BIST_SCANOUT_EN
   logic so_q;
   assign SO = so_q;
`endif

   always_ff @(posedge CK) begin
      if (R) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED;
         misr_q  <= '0;
         cnt_q   <= '0;
         stim_q  <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         hist_q  <= '0;
`ifdef KISTA_BIST_SCANOUT_EN
         so_q    <= 1'b0;
`endif
      end else begin
         hist_q <= hist_d[6:0];
         misr_q <= misr_nxt_d;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (START) begin
                  // First stimulus goes out with the state change; LFSR is one step ahead
                  state_q <= S_RUN;
                  lfsr_q  <= step(SEED);
                  stim_q  <= SEED[1:0];
                  misr_q  <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  hist_q  <= '0;
               end
`ifdef KISTA_BIST_SCANOUT_EN
               else if (state_q == S_DONE && SHIFT) begin
                  misr_q <= {misr_q[LFSR_W-2:0], 1'b0};
                  so_q   <= misr_q[LFSR_W-1];
               end
`endif
            end
            S_RUN: begin
               if (cnt_q == NCYC_LAST) begin
                  cnt_q <= '0;
                  if (LAT == 0) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (misr_nxt_d == GOLDEN);
                  end else begin
                     state_q <= S_DRAIN;
                  end
               end else begin
                  cnt_q  <= cnt_q + 16'd1;
                  stim_q <= lfsr_q[1:0];
                  lfsr_q <= step(lfsr_q);
               end
            end
            S_DRAIN: begin
               if (cnt_q == LAT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (misr_nxt_d == GOLDEN);
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign STIM = stim_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
   assign PASS = pass_q;
   assign SIG  = misr_q;

endmodule
